// File: rtl/sr_flag_pkg.sv
// ---------------------------------------------------------------------------
// sr_flag_pkg
// Shared definitions for the sr_flag_bank set/reset flag bank.
//   sr_mode_e : behaviour of a flag channel when set and reset are both high
//   SR_MAX_N  : largest supported number of flag channels
// ---------------------------------------------------------------------------
package sr_flag_pkg;

  localparam int SR_MAX_N = 32;

  typedef enum logic [1:0] {
    SR_SET_DOM = 2'd0,  // set wins
    SR_RST_DOM = 2'd1,  // reset wins
    SR_HOLD    = 2'd2,  // keep previous value
    SR_TOGGLE  = 2'd3   // invert previous value
  } sr_mode_e;

endpackage : sr_flag_pkg

// File: rtl/sr_cell.sv
// ---------------------------------------------------------------------------
// sr_cell
// One clocked set/reset flag channel.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous reset, active-high (q_o -> 0)
//   s_i     : set request
//   r_i     : reset request
//   clr_i   : read-clear request; lowest priority, ignored while s_i=1
//   mode_i  : action taken when s_i and r_i are both high
//   q_o     : registered flag state
// ---------------------------------------------------------------------------
module sr_cell
  import sr_flag_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     s_i,
  input  logic     r_i,
  input  logic     clr_i,
  input  sr_mode_e mode_i,
  output logic     q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case ({s_i, r_i})
      2'b11: begin
        unique case (mode_i)
          SR_SET_DOM: q_d = 1'b1;
          SR_RST_DOM: q_d = 1'b0;
          SR_HOLD:    q_d = q_q;
          SR_TOGGLE:  q_d = ~q_q;
          default:    q_d = q_q;
        endcase
      end
      2'b10:   q_d = 1'b1;
      2'b01:   q_d = 1'b0;
      default: begin
        // Read-clear only acts when no set arrives this cycle, so an event
        // landing on the read cycle survives into the next snapshot.
        if (clr_i) q_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule : sr_cell

// File: rtl/sr_flag_bank.sv
// ---------------------------------------------------------------------------
// sr_flag_bank
// Bank of N clocked set/reset flags with masked interrupt, a one-cycle
// snapshot read (optionally clear-on-read) and an optional saturating
// counter of cycles in which any channel saw set and reset together.
//
// Build option: define SR_CONFLICT_CNT_EN to build the conflict counter;
// otherwise conflict_cnt is tied to 0 (port list unchanged).
//
// Parameters:
//   N         : number of flag channels (1..SR_MAX_N)
//   MODE      : channel behaviour when s=r=1
//   CLR_ON_RD : 1 = flags returned by a read are cleared at capture
//   CNT_W     : conflict counter width
// Ports:
//   clk           : clock, rising edge
//   rst           : synchronous reset, active-high
//   s, r          : per-channel set / reset
//   irq_mask      : 1 = channel contributes to irq
//   q, qn         : flag state and its complement
//   irq           : |(q & irq_mask), from registers
//   rd_req        : snapshot request
//   rd_valid      : pulses the cycle after rd_req
//   rd_data       : snapshot of q taken on the rd_req cycle (held otherwise)
//   conflict_cnt  : saturating count of cycles with any s&r
//
// Read handshake: rd_req high at edge k produces rd_valid high for exactly
// the cycle after edge k with rd_data = q as it was before edge k. There is
// no backpressure; every request cycle yields one valid cycle.
// ---------------------------------------------------------------------------
module sr_flag_bank
  import sr_flag_pkg::*;
#(
  parameter int       N         = 8,
  parameter sr_mode_e MODE      = SR_SET_DOM,
  parameter int       CLR_ON_RD = 1,
  parameter int       CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     s,
  input  logic [N-1:0]     r,
  input  logic [N-1:0]     irq_mask,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qn,
  output logic             irq,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [N-1:0]     rd_data,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [N-1:0] flag_q;
  logic [N-1:0] clr_vec;

  logic         rd_valid_q;
  logic         rd_valid_d;
  logic [N-1:0] rd_data_q;
  logic [N-1:0] rd_data_d;

  // Only channels that are 1 in the snapshot get cleared; the cell itself
  // lets a same-cycle set override this.
  always_comb begin
    clr_vec = '0;
    if ((CLR_ON_RD != 0) && rd_req) clr_vec = flag_q;
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    sr_cell u_cell (
      .clk_i  (clk),
      .rst_i  (rst),
      .s_i    (s[i]),
      .r_i    (r[i]),
      .clr_i  (clr_vec[i]),
      .mode_i (MODE),
      .q_o    (flag_q[i])
    );
  end

  assign q   = flag_q;
  assign qn  = ~flag_q;
  assign irq = |(flag_q & irq_mask);

  // Snapshot path
  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    if (rd_req) rd_data_d = flag_q;
  end

  // A request coinciding with reset is dropped along with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

`ifdef SR_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating at all-ones; only reset brings it back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if ((|(s & r)) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule : sr_flag_bank
